seg_pattern_decoder: RTL and testbench
======================================

Name: seg_pattern_decoder

Overview:
- Inverse of the seven-segment display path: takes a 7-bit lit-segment pattern (e.g. from the user-drawn segment canvas) and recovers the digit it represents.
- Filters the pattern for stability, then presents `valid` / `valid_number` for the consumer that drives the 7-seg display.
- Sits between the segment-drawing logic and the display driver. Fully synchronous on `clock`.

Parameters:
- STABLE_CYCLES, 4: consecutive cycles a recognised pattern must be held before lock. Legal range is 2 or more.
- ACTIVE_LOW, 0: 1 = `segs_in` bits are active-low (lit = 0), as on the board segment pins. The input is inverted internally before decode.
- ACCEPT_ALT, 1: 1 = also accept the alternate glyphs 6-without-a, 9-without-d and 7-with-f.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- clear  in  1  synchronous; abandons any lock and returns to IDLE
- segs_in  in  7  segment pattern; bit0=a, bit1=b … bit6=g
- valid  out  1  high while a digit is locked
- valid_number  out  4  locked digit 0–9; holds last locked value when valid=0
- new_digit  out  1  one-cycle pulse on the cycle valid rises or the locked digit changes
- invalid  out  1  high while the captured pattern is non-blank and unrecognised

Behaviour:
- Reset (reset_n=0 at an edge):
  - state=IDLE, seg_q=0, cnt=0.
  - valid=0, valid_number=0, new_digit=0, invalid=0.
  - Reset has priority over clear and all other inputs.
- Normalisation: p = ACTIVE_LOW ? ~segs_in : segs_in.
- Capture: seg_q <= p every edge. Decode is combinational on seg_q.
- Decode table (active-high, g..a), matches are exact:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - If ACCEPT_ALT=1, also accept 7C→6, 67→9, 27→7.
  - Every other pattern, including 00, is unrecognised.
- same = (p == seg_q).
- FSM states: IDLE, SETTLE, LOCKED.
  - IDLE: if decode(p) is recognised → SETTLE, cnt=0.
  - SETTLE, same and recognised, cnt < STABLE_CYCLES-1: cnt++.
  - SETTLE, same and recognised, cnt == STABLE_CYCLES-1: → LOCKED; valid<=1; valid_number<=digit; new_digit<=1.
  - SETTLE, !same: if p is recognised, restart (stay in SETTLE, cnt=0); else → IDLE.
  - LOCKED, same: stay; valid=1; new_digit=0.
  - LOCKED, !same: valid<=0 on that edge. If p is recognised → SETTLE, cnt=0; else → IDLE.
  - A re-lock to the same digit after a glitch still pulses new_digit.
- Latency: pattern P first present before edge 0 and held → valid rises at edge STABLE_CYCLES (edge 4 at default).
- cnt width is $clog2(STABLE_CYCLES). cnt saturates and never wraps.
- invalid: registered. invalid <= (p != 0) && !recognised(p). Independent of FSM state; cleared by reset only.
- clear=1 at an edge:
  - state=IDLE, cnt=0, valid=0, new_digit=0.
  - valid_number holds its value; seg_q is still captured.
  - While clear is held, no lock can occur.
  - After clear drops, a held pattern re-qualifies from IDLE, so valid rises STABLE_CYCLES+1 edges after the first edge with clear=0.
- Simultaneous clear with a would-be lock: clear wins, and there is no new_digit pulse.
- new_digit is never high for more than one consecutive cycle.

Decomposition:
- Shared package `seg_pkg`:
  - the ten canonical segment constants and three alternate-glyph constants;
  - segment bit-index constants A..G;
  - FSM state encoding (2-bit).
- Sub-module `seg_pattern_lookup`: combinational; inputs pattern[6:0] and accept_alt; outputs hit and digit[3:0]. It is reused by the decoder and by the bench's scoreboard model.

Test Plan:
- Reset and lock: hold reset_n=0 for 3 edges, then apply segs_in=7'h5B → valid=0 through edge 3; at edge 4 valid=1, valid_number=2, new_digit=1 for exactly one cycle.
- Glitch restart: apply 7'h4F, and at edge 2 present 7'h06 for one cycle, then 7'h4F again → no lock to 1 or 3 until 4 clean edges after the return; final valid_number=3.
- Locked change: locked on 8 (7F), switch to 7'h6F → valid drops at the switch edge, re-rises 4 edges later with valid_number=9 and a new_digit pulse.
- Unrecognised and blank: apply 7'h01 → invalid=1 after 1 edge, valid stays 0; apply 7'h00 → invalid=0, valid=0, valid_number keeps its last value.
- Alternates and polarity: with ACCEPT_ALT=1, 7'h7C → 6. With ACCEPT_ALT=0, 7'h7C → invalid=1. With ACTIVE_LOW=1, segs_in=~7'h66 → 4.
- Clear priority: while locked on 5, assert clear on the lock edge of a new pattern → valid=0, no new_digit, valid_number=5. Release clear → relock after STABLE_CYCLES+1 edges.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the segment-pattern decoder: segment bit positions,
// canonical and alternate digit glyphs, and the settle/lock FSM encoding.
package seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_MASK_A = 7'(1) << SEG_A;
  localparam logic [6:0] SEG_MASK_B = 7'(1) << SEG_B;
  localparam logic [6:0] SEG_MASK_C = 7'(1) << SEG_C;
  localparam logic [6:0] SEG_MASK_D = 7'(1) << SEG_D;
  localparam logic [6:0] SEG_MASK_E = 7'(1) << SEG_E;
  localparam logic [6:0] SEG_MASK_F = 7'(1) << SEG_F;
  localparam logic [6:0] SEG_MASK_G = 7'(1) << SEG_G;

  // Glyphs spelled out by lit segment so each table entry reads like the display.
  localparam logic [6:0] SEG_DIG_0 = SEG_MASK_A | SEG_MASK_B | SEG_MASK_C | SEG_MASK_D | SEG_MASK_E | SEG_MASK_F;
  localparam logic [6:0] SEG_DIG_1 = SEG_MASK_B | SEG_MASK_C;
  localparam logic [6:0] SEG_DIG_2 = SEG_MASK_A | SEG_MASK_B | SEG_MASK_D | SEG_MASK_E | SEG_MASK_G;
  localparam logic [6:0] SEG_DIG_3 = SEG_MASK_A | SEG_MASK_B | SEG_MASK_C | SEG_MASK_D | SEG_MASK_G;
  localparam logic [6:0] SEG_DIG_4 = SEG_MASK_B | SEG_MASK_C | SEG_MASK_F | SEG_MASK_G;
  localparam logic [6:0] SEG_DIG_5 = SEG_MASK_A | SEG_MASK_C | SEG_MASK_D | SEG_MASK_F | SEG_MASK_G;
  localparam logic [6:0] SEG_DIG_6 = SEG_MASK_A | SEG_MASK_C | SEG_MASK_D | SEG_MASK_E | SEG_MASK_F | SEG_MASK_G;
  localparam logic [6:0] SEG_DIG_7 = SEG_MASK_A | SEG_MASK_B | SEG_MASK_C;
  localparam logic [6:0] SEG_DIG_8 = SEG_MASK_A | SEG_MASK_B | SEG_MASK_C | SEG_MASK_D | SEG_MASK_E | SEG_MASK_F | SEG_MASK_G;
  localparam logic [6:0] SEG_DIG_9 = SEG_MASK_A | SEG_MASK_B | SEG_MASK_C | SEG_MASK_D | SEG_MASK_F | SEG_MASK_G;

  localparam logic [6:0] SEG_ALT_6 = SEG_MASK_C | SEG_MASK_D | SEG_MASK_E | SEG_MASK_F | SEG_MASK_G;
  localparam logic [6:0] SEG_ALT_9 = SEG_MASK_A | SEG_MASK_B | SEG_MASK_C | SEG_MASK_F | SEG_MASK_G;
  localparam logic [6:0] SEG_ALT_7 = SEG_MASK_A | SEG_MASK_B | SEG_MASK_C | SEG_MASK_F;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } seg_state_t;

  // Board segment pins are active-low; the decode table is active-high.
  function automatic logic [6:0] seg_normalise(input logic [6:0] raw, input logic active_low);
    return active_low ? ~raw : raw;
  endfunction

endpackage

// File: rtl/seg_pattern_lookup.sv
// Combinational glyph matcher: exact match of a 7-bit active-high pattern
// against the digit table, optionally including the alternate glyphs.
module seg_pattern_lookup
  import seg_pkg::*;
(
  input  logic [6:0] pattern,
  input  logic       accept_alt,
  output logic       hit,
  output logic [3:0] digit
);

  always_comb begin
    hit   = 1'b1;
    digit = 4'd0;
    case (pattern)
      SEG_DIG_0: digit = 4'd0;
      SEG_DIG_1: digit = 4'd1;
      SEG_DIG_2: digit = 4'd2;
      SEG_DIG_3: digit = 4'd3;
      SEG_DIG_4: digit = 4'd4;
      SEG_DIG_5: digit = 4'd5;
      SEG_DIG_6: digit = 4'd6;
      SEG_DIG_7: digit = 4'd7;
      SEG_DIG_8: digit = 4'd8;
      SEG_DIG_9: digit = 4'd9;
      // Alternates only count when enabled; digit stays 0 on a miss.
      SEG_ALT_6: begin
        hit   = accept_alt;
        digit = accept_alt ? 4'd6 : 4'd0;
      end
      SEG_ALT_9: begin
        hit   = accept_alt;
        digit = accept_alt ? 4'd9 : 4'd0;
      end
      SEG_ALT_7: begin
        hit   = accept_alt;
        digit = accept_alt ? 4'd7 : 4'd0;
      end
      default: hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_pattern_decoder.sv
// Recovers a digit from a lit-segment pattern: captures the pattern, requires
// it to be held STABLE_CYCLES edges, then presents it as a locked digit.
module seg_pattern_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter bit ACCEPT_ALT    = 1'b1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       clear,
  input  logic [6:0] segs_in,
  output logic       valid,
  output logic [3:0] valid_number,
  output logic       new_digit,
  output logic       invalid
);

  localparam int CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic [6:0]       p;
  logic [6:0]       seg_q;
  logic             same;
  logic             hit_p;
  logic [3:0]       digit_p;

  seg_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             valid_reg, valid_next;
  logic [3:0]       number_reg, number_next;
  logic             new_digit_reg, new_digit_next;
  logic             invalid_reg, invalid_next;

  assign p    = seg_normalise(segs_in, ACTIVE_LOW);
  assign same = (p == seg_q);

  // Matching the incoming pattern: when same is true it equals seg_q, so the
  // lock decision is identical to decoding the captured pattern.
  seg_pattern_lookup u_lookup (
    .pattern    (p),
    .accept_alt (ACCEPT_ALT),
    .hit        (hit_p),
    .digit      (digit_p)
  );

  assign invalid_next = (p != 7'd0) && !hit_p;

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    valid_next     = valid_reg;
    number_next    = number_reg;
    new_digit_next = 1'b0;
    if (clear) begin
      state_next = ST_IDLE;
      cnt_next   = '0;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (hit_p) begin
            state_next = ST_SETTLE;
            cnt_next   = '0;
          end
        end
        ST_SETTLE: begin
          if (same && hit_p) begin
            if (cnt_reg == CNT_LAST) begin
              state_next     = ST_LOCKED;
              valid_next     = 1'b1;
              number_next    = digit_p;
              new_digit_next = 1'b1;
            end else begin
              cnt_next = cnt_reg + 1'b1;
            end
          end else if (hit_p) begin
            cnt_next = '0;
          end else begin
            state_next = ST_IDLE;
            cnt_next   = '0;
          end
        end
        ST_LOCKED: begin
          // Any change drops the lock; a recognised newcomer starts settling.
          if (!same) begin
            valid_next = 1'b0;
            cnt_next   = '0;
            state_next = hit_p ? ST_SETTLE : ST_IDLE;
          end
        end
        default: begin
          state_next = ST_IDLE;
          cnt_next   = '0;
          valid_next = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      seg_q         <= 7'd0;
      cnt_reg       <= '0;
      valid_reg     <= 1'b0;
      number_reg    <= 4'd0;
      new_digit_reg <= 1'b0;
      invalid_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      seg_q         <= p;
      cnt_reg       <= cnt_next;
      valid_reg     <= valid_next;
      number_reg    <= number_next;
      new_digit_reg <= new_digit_next;
      invalid_reg   <= invalid_next;
    end
  end

  assign valid        = valid_reg;
  assign valid_number = number_reg;
  assign new_digit    = new_digit_reg;
  assign invalid      = invalid_reg;

endmodule

// File: tb/tb_seg_pattern_decoder.sv
// Directed bench for seg_pattern_decoder: default, no-alternates and
// active-low instances share one stimulus stream; glyph table checked directly.
module tb_seg_pattern_decoder;

  logic       clock;
  logic       reset_n;
  logic       clear;
  logic [6:0] segs;
  logic [6:0] segs_n;

  logic       v1, nd1, i1;
  logic [3:0] n1;
  logic       v2, nd2, i2;
  logic [3:0] n2;
  logic       v3, nd3, i3;
  logic [3:0] n3;

  logic [6:0] lk_pat;
  logic       lk_alt;
  logic       lk_hit;
  logic [3:0] lk_digit;

  int errors = 0;
  int checks = 0;

  assign segs_n = ~segs;

  seg_pattern_decoder u_dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .segs_in(segs),
    .valid(v1), .valid_number(n1), .new_digit(nd1), .invalid(i1)
  );

  seg_pattern_decoder #(.ACCEPT_ALT(1'b0)) u_dut_noalt (
    .clock(clock), .reset_n(reset_n), .clear(clear), .segs_in(segs),
    .valid(v2), .valid_number(n2), .new_digit(nd2), .invalid(i2)
  );

  seg_pattern_decoder #(.ACTIVE_LOW(1'b1)) u_dut_al (
    .clock(clock), .reset_n(reset_n), .clear(clear), .segs_in(segs_n),
    .valid(v3), .valid_number(n3), .new_digit(nd3), .invalid(i3)
  );

  seg_pattern_lookup u_lk (
    .pattern(lk_pat), .accept_alt(lk_alt), .hit(lk_hit), .digit(lk_digit)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  // pattern, accept_alt, expected hit, expected digit
  logic [6:0] lk_vp [18] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F,
                             7'h6F, 7'h7C, 7'h7C, 7'h67, 7'h67, 7'h27, 7'h27, 7'h00, 7'h7E};
  logic       lk_va [18] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1,
                             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
  logic       lk_vh [18] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                             1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [3:0] lk_vd [18] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8,
                             4'd9, 4'd6, 4'd0, 4'd9, 4'd0, 4'd7, 4'd0, 4'd0, 4'd0};

  initial begin
    reset_n = 1'b0;
    clear   = 1'b0;
    segs    = 7'h00;
    lk_pat  = 7'h00;
    lk_alt  = 1'b1;

    for (int i = 0; i < 18; i++) begin
      lk_pat = lk_vp[i];
      lk_alt = lk_va[i];
      #1;
      $display("lookup pat=%02h alt=%0d hit=%0d digit=%0d", lk_pat, lk_alt, lk_hit, lk_digit);
      check($sformatf("lk_hit_%02h_%0d", lk_vp[i], lk_va[i]), {7'd0, lk_hit}, {7'd0, lk_vh[i]});
      if (lk_vh[i])
        check($sformatf("lk_digit_%02h", lk_vp[i]), {4'd0, lk_digit}, {4'd0, lk_vd[i]});
    end

    // Reset, then lock on 2
    step(3);
    check("rst_valid", {7'd0, v1}, 8'd0);
    check("rst_number", {4'd0, n1}, 8'd0);
    check("rst_new_digit", {7'd0, nd1}, 8'd0);
    check("rst_invalid", {7'd0, i1}, 8'd0);
    reset_n = 1'b1;
    segs = 7'h5B;
    for (int e = 0; e < 4; e++) begin
      step(1);
      check($sformatf("lock2_wait_e%0d", e), {7'd0, v1}, 8'd0);
    end
    check("lock2_invalid", {7'd0, i1}, 8'd0);
    check("lock2_al_invalid", {7'd0, i3}, 8'd0);
    step(1);
    $display("txn lock 5B: valid=%0d number=%0d new_digit=%0d", v1, n1, nd1);
    check("lock2_valid", {7'd0, v1}, 8'd1);
    check("lock2_number", {4'd0, n1}, 8'd2);
    check("lock2_new_digit", {7'd0, nd1}, 8'd1);
    step(1);
    check("lock2_pulse_end", {7'd0, nd1}, 8'd0);
    check("lock2_hold", {7'd0, v1}, 8'd1);

    // Glitch restart: 4F, one cycle of 06 at edge 2, back to 4F
    segs = 7'h4F;
    step(1);
    check("glitch_drop", {7'd0, v1}, 8'd0);
    step(1);
    check("glitch_e1", {7'd0, v1}, 8'd0);
    segs = 7'h06;
    step(1);
    check("glitch_e2", {7'd0, v1}, 8'd0);
    segs = 7'h4F;
    for (int e = 3; e < 7; e++) begin
      step(1);
      check($sformatf("glitch_wait_e%0d", e), {7'd0, v1}, 8'd0);
    end
    step(1);
    $display("txn glitch 4F/06/4F: valid=%0d number=%0d new_digit=%0d", v1, n1, nd1);
    check("glitch_valid", {7'd0, v1}, 8'd1);
    check("glitch_number", {4'd0, n1}, 8'd3);
    check("glitch_new_digit", {7'd0, nd1}, 8'd1);

    // Locked change 8 -> 9
    segs = 7'h7F;
    step(4);
    check("lock8_wait", {7'd0, v1}, 8'd0);
    step(1);
    check("lock8_number", {4'd0, n1}, 8'd8);
    check("lock8_new_digit", {7'd0, nd1}, 8'd1);
    segs = 7'h6F;
    step(1);
    check("chg_drop", {7'd0, v1}, 8'd0);
    check("chg_hold_number", {4'd0, n1}, 8'd8);
    step(3);
    check("chg_wait", {7'd0, v1}, 8'd0);
    step(1);
    $display("txn change 7F->6F: valid=%0d number=%0d new_digit=%0d", v1, n1, nd1);
    check("chg_valid", {7'd0, v1}, 8'd1);
    check("chg_number", {4'd0, n1}, 8'd9);
    check("chg_new_digit", {7'd0, nd1}, 8'd1);
    step(1);
    check("chg_pulse_end", {7'd0, nd1}, 8'd0);

    // Unrecognised, then blank
    segs = 7'h01;
    step(1);
    $display("txn unrecognised 01: valid=%0d invalid=%0d", v1, i1);
    check("unrec_invalid", {7'd0, i1}, 8'd1);
    check("unrec_valid", {7'd0, v1}, 8'd0);
    segs = 7'h00;
    step(1);
    $display("txn blank 00: valid=%0d invalid=%0d number=%0d", v1, i1, n1);
    check("blank_invalid", {7'd0, i1}, 8'd0);
    check("blank_valid", {7'd0, v1}, 8'd0);
    check("blank_number", {4'd0, n1}, 8'd9);
    step(2);
    check("blank_stay", {7'd0, v1}, 8'd0);

    // Alternate 6 glyph with and without acceptance
    segs = 7'h7C;
    step(1);
    check("alt_invalid", {7'd0, i1}, 8'd0);
    check("noalt_invalid", {7'd0, i2}, 8'd1);
    step(3);
    check("alt_wait", {7'd0, v1}, 8'd0);
    step(1);
    $display("txn alt 7C: valid=%0d number=%0d | noalt valid=%0d invalid=%0d", v1, n1, v2, i2);
    check("alt_valid", {7'd0, v1}, 8'd1);
    check("alt_number", {4'd0, n1}, 8'd6);
    check("alt_new_digit", {7'd0, nd1}, 8'd1);
    check("noalt_valid", {7'd0, v2}, 8'd0);
    check("noalt_new_digit", {7'd0, nd2}, 8'd0);
    check("noalt_number", {4'd0, n2}, 8'd9);

    // Active-low instance sees ~66
    segs = 7'h66;
    step(5);
    $display("txn active-low ~66: valid=%0d number=%0d new_digit=%0d", v3, n3, nd3);
    check("al_valid", {7'd0, v3}, 8'd1);
    check("al_number", {4'd0, n3}, 8'd4);
    check("al_new_digit", {7'd0, nd3}, 8'd1);

    // Clear on the would-be lock edge while locked on 5
    segs = 7'h6D;
    step(5);
    check("lock5_number", {4'd0, n1}, 8'd5);
    check("lock5_valid", {7'd0, v1}, 8'd1);
    segs = 7'h3F;
    step(4);
    check("clr_pre", {7'd0, v1}, 8'd0);
    clear = 1'b1;
    step(1);
    $display("txn clear on lock edge: valid=%0d new_digit=%0d number=%0d", v1, nd1, n1);
    check("clr_valid", {7'd0, v1}, 8'd0);
    check("clr_new_digit", {7'd0, nd1}, 8'd0);
    check("clr_number", {4'd0, n1}, 8'd5);
    step(3);
    check("clr_held", {7'd0, v1}, 8'd0);
    clear = 1'b0;
    step(4);
    check("clr_release_wait", {7'd0, v1}, 8'd0);
    step(1);
    $display("txn relock after clear: valid=%0d number=%0d new_digit=%0d", v1, n1, nd1);
    check("clr_relock_valid", {7'd0, v1}, 8'd1);
    check("clr_relock_number", {4'd0, n1}, 8'd0);
    check("clr_relock_new_digit", {7'd0, nd1}, 8'd1);
    step(1);
    check("clr_relock_pulse_end", {7'd0, nd1}, 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
